// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding,
// default tag/physical-register widths and the flush-age comparison.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DEF_TAG_W = 5;
    localparam int DEF_PHY_W = 6;

    // True when the held divide is younger than the flushing branch:
    // age = (tag - top) mod 2^tag_w, killed when age > depth.
    function automatic logic flush_kill(
        input logic [31:0] tag,
        input logic [31:0] top,
        input logic [31:0] depth,
        input int          tag_w
    );
        logic [31:0] mask;
        logic [31:0] age;
        mask = (32'd1 << tag_w) - 32'd1;
        age  = (tag - top) & mask;
        return (age > (depth & mask));
    endfunction

endpackage

// File: rtl/div_iter_unit_if.sv
// Issue / flush / CDB bundle of the iterative divider. The master side is the
// issue unit + CDB arbiter, the slave side is div_iter_unit.
interface div_iter_unit_if
    import div_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = DEF_TAG_W,
    parameter int PHY_W = DEF_PHY_W
);
    logic [31:0]        PhyReg_DivRsData;
    logic [31:0]        PhyReg_DivRtData;
    logic               Iss_Div;
    logic               Iss_DivSigned;
    logic [TAG_W-1:0]   Iss_RobTag;
    logic [PHY_W-1:0]   Iss_RdPhyAddr;
    logic               Iss_RdWrite;
    logic               Cdb_Flush;
    logic [TAG_W-1:0]   Rob_TopPtr;
    logic [TAG_W-1:0]   Cdb_RobDepth;
    logic               Cdb_DivAccept;
    logic               Div_Done;
    logic [2*WIDTH-1:0] Div_Rddata;
    logic [TAG_W-1:0]   Div_RobTag;
    logic [PHY_W-1:0]   Div_RdPhyAddr;
    logic               Div_RdWrite;
    logic               Div_ExeRdy;

    modport master (
        output PhyReg_DivRsData, PhyReg_DivRtData, Iss_Div, Iss_DivSigned,
               Iss_RobTag, Iss_RdPhyAddr, Iss_RdWrite, Cdb_Flush, Rob_TopPtr,
               Cdb_RobDepth, Cdb_DivAccept,
        input  Div_Done, Div_Rddata, Div_RobTag, Div_RdPhyAddr, Div_RdWrite,
               Div_ExeRdy
    );

    modport slave (
        input  PhyReg_DivRsData, PhyReg_DivRtData, Iss_Div, Iss_DivSigned,
               Iss_RobTag, Iss_RdPhyAddr, Iss_RdWrite, Cdb_Flush, Rob_TopPtr,
               Cdb_RobDepth, Cdb_DivAccept,
        output Div_Done, Div_Rddata, Div_RobTag, Div_RdPhyAddr, Div_RdWrite,
               Div_ExeRdy
    );

endinterface

// File: rtl/div_iter_unit_chk.sv
// Protocol checker: an issue while the unit is not ready is illegal.
module div_iter_unit_chk (
    input logic clk,
    input logic rst,
    input logic iss_div,
    input logic exe_rdy
);

    // Flag Iss_Div outside a ready cycle.
    always_ff @(posedge clk) begin
        if (!rst && iss_div) begin
            assert (exe_rdy);
        end
    end

endmodule

// File: rtl/div_restore_step.sv
// One restoring-division step: shift the partial remainder left, bring in
// the next dividend bit, subtract the divisor when it fits.
module div_restore_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH-1:0] diff_s;

    // Compare-subtract; the true difference is below the divisor so the low
    // WIDTH bits of the modular subtraction are exact.
    always_comb begin
        shifted_s = {rem, dvd_bit};
        diff_s    = shifted_s[WIDTH-1:0] - dvs;
        if (shifted_s >= {1'b0, dvs}) begin
            rem_next = diff_s;
            q_bit    = 1'b1;
        end else begin
            rem_next = shifted_s[WIDTH-1:0];
            q_bit    = 1'b0;
        end
    end

endmodule

// File: rtl/div_iter_unit.sv
// Iterative restoring divider for the Tomasulo execution stage: one
// quotient bit per clock, result held until the CDB accepts it, and
// squashed by a flush younger than the mispredicted branch.
// Optional feature: define DIV_SIGNED_EN to honour Iss_DivSigned
// (magnitude conversion + sign fix); otherwise every divide is unsigned.
module div_iter_unit
    import div_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = DEF_TAG_W,
    parameter int PHY_W = DEF_PHY_W
) (
    input logic            Clk,
    input logic            Reset,
    div_iter_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e         state_r;
    div_state_e         state_s;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   dvd_r;
    logic [WIDTH-1:0]   dvs_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [2*WIDTH-1:0] result_r;
    logic [TAG_W-1:0]   tag_r;
    logic [PHY_W-1:0]   phy_r;
    logic               wr_r;
    logic               zero_r;
`ifdef DIV_SIGNED_EN
    logic               neg_q_r;
    logic               neg_r_r;
`endif

    logic               kill_s;
    logic               exe_rdy_s;
    logic               load_s;
    logic               last_s;
    logic [WIDTH-1:0]   a_raw_s;
    logic [WIDTH-1:0]   b_raw_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [WIDTH-1:0]   rem_next_s;
    logic               q_bit_s;
    logic [WIDTH-1:0]   quo_raw_s;
    logic [WIDTH-1:0]   quo_fin_s;
    logic [WIDTH-1:0]   rem_fin_s;
    logic               unused_s;

    assign a_raw_s  = bus.PhyReg_DivRsData[WIDTH-1:0];
    assign b_raw_s  = bus.PhyReg_DivRtData[WIDTH-1:0];
    assign unused_s = ^{bus.PhyReg_DivRsData, bus.PhyReg_DivRtData, bus.Iss_DivSigned};

    assign kill_s = bus.Cdb_Flush
                  & ((state_r == CALC) | (state_r == DONE))
                  & flush_kill({{(32-TAG_W){1'b0}}, tag_r},
                               {{(32-TAG_W){1'b0}}, bus.Rob_TopPtr},
                               {{(32-TAG_W){1'b0}}, bus.Cdb_RobDepth},
                               TAG_W);

    assign exe_rdy_s = (state_r == IDLE)
                     | ((state_r == DONE) & bus.Cdb_DivAccept & ~kill_s)
                     | kill_s;
    assign load_s    = bus.Iss_Div & exe_rdy_s;
    assign last_s    = (cnt_r == CNT_W'(1));

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_r),
        .dvd_bit  (dvd_r[WIDTH-1]),
        .dvs      (dvs_r),
        .rem_next (rem_next_s),
        .q_bit    (q_bit_s)
    );

    assign quo_raw_s = {dvd_r[WIDTH-2:0], q_bit_s};

    // Operand magnitudes at issue (signed operands are made positive).
    always_comb begin
        a_mag_s = a_raw_s;
        b_mag_s = b_raw_s;
`ifdef DIV_SIGNED_EN
        if (bus.Iss_DivSigned && a_raw_s[WIDTH-1]) begin
            a_mag_s = -a_raw_s;
        end else begin
            a_mag_s = a_raw_s;
        end
        if (bus.Iss_DivSigned && b_raw_s[WIDTH-1]) begin
            b_mag_s = -b_raw_s;
        end else begin
            b_mag_s = b_raw_s;
        end
`endif
    end

    // Final quotient/remainder: divide-by-zero saturates to all ones,
    // otherwise the sign fix is applied to the magnitude result.
    always_comb begin
        quo_fin_s = quo_raw_s;
        rem_fin_s = rem_next_s;
        if (zero_r) begin
            quo_fin_s = {WIDTH{1'b1}};
            rem_fin_s = {WIDTH{1'b1}};
        end else begin
`ifdef DIV_SIGNED_EN
            quo_fin_s = neg_q_r ? -quo_raw_s : quo_raw_s;
            rem_fin_s = neg_r_r ? -rem_next_s : rem_next_s;
`else
            quo_fin_s = quo_raw_s;
            rem_fin_s = rem_next_s;
`endif
        end
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state: kill and accept both free the unit, and a same-cycle
    // issue goes straight back to CALC.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (load_s) begin
                    state_s = CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (kill_s) begin
                    state_s = load_s ? CALC : IDLE;
                end else if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE: begin
                if (kill_s || bus.Cdb_DivAccept) begin
                    state_s = load_s ? CALC : IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Datapath: capture on issue, one restoring step per CALC cycle, and
    // register the final result on the last step.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rem_r    <= {WIDTH{1'b0}};
            dvd_r    <= {WIDTH{1'b0}};
            dvs_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            result_r <= {(2*WIDTH){1'b0}};
            tag_r    <= {TAG_W{1'b0}};
            phy_r    <= {PHY_W{1'b0}};
            wr_r     <= 1'b0;
            zero_r   <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
`endif
        end else if (load_s) begin
            rem_r    <= {WIDTH{1'b0}};
            dvd_r    <= a_mag_s;
            dvs_r    <= b_mag_s;
            cnt_r    <= CNT_W'(WIDTH);
            tag_r    <= bus.Iss_RobTag;
            phy_r    <= bus.Iss_RdPhyAddr;
            wr_r     <= bus.Iss_RdWrite;
            zero_r   <= (b_raw_s == {WIDTH{1'b0}});
`ifdef DIV_SIGNED_EN
            neg_q_r  <= bus.Iss_DivSigned & (a_raw_s[WIDTH-1] ^ b_raw_s[WIDTH-1]);
            neg_r_r  <= bus.Iss_DivSigned & a_raw_s[WIDTH-1];
`endif
        end else if ((state_r == CALC) && !kill_s) begin
            rem_r <= rem_next_s;
            dvd_r <= quo_raw_s;
            cnt_r <= cnt_r - CNT_W'(1);
            if (last_s) begin
                result_r <= {rem_fin_s, quo_fin_s};
            end
        end
    end

    assign bus.Div_Done      = (state_r == DONE) & ~kill_s;
    assign bus.Div_Rddata    = result_r;
    assign bus.Div_RobTag    = tag_r;
    assign bus.Div_RdPhyAddr = phy_r;
    assign bus.Div_RdWrite   = wr_r;
    assign bus.Div_ExeRdy    = exe_rdy_s;

    div_iter_unit_chk u_chk (
        .clk     (Clk),
        .rst     (Reset),
        .iss_div (bus.Iss_Div),
        .exe_rdy (exe_rdy_s)
    );

endmodule
